// File: rtl/tea_pkg.sv
// rtl/tea_pkg.sv - shared types, key-schedule constant and FSM states for the TEA stream engine
package tea_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [63:0]  block_t;
  typedef logic [127:0] key_t;

  localparam word_t DELTA = 32'h9E3779B9;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Decryption starts from the sum that encryption ends on.
  function automatic word_t dec_init_sum(input word_t delta, input int unsigned cycles);
    return word_t'(delta * word_t'(cycles));
  endfunction

  function automatic word_t key_word(input key_t key, input logic [1:0] idx);
    return key[{idx, 5'b00000} +: 32];
  endfunction

endpackage

// File: rtl/tea_round.sv
// rtl/tea_round.sv - one combinational Feistel cycle (two rounds); XTEA path only with TEA_STREAM_XTEA_EN
module tea_round
  import tea_pkg::*;
#(
  parameter logic [31:0] DELTA = tea_pkg::DELTA
) (
  input  logic [31:0]  v0,
  input  logic [31:0]  v1,
  input  logic [31:0]  sum,
  input  logic [127:0] key,
  input  logic         dec,
  input  logic         alg,
  output logic [31:0]  v0_o,
  output logic [31:0]  v1_o,
  output logic [31:0]  sum_o
);

  function automatic word_t tea_f(input word_t v, input word_t s, input word_t ka, input word_t kb);
    return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
  endfunction

  word_t k0, k1, k2, k3;
  word_t s_mid;

  assign k0 = key[31:0];
  assign k1 = key[63:32];
  assign k2 = key[95:64];
  assign k3 = key[127:96];

`ifdef TEA_STREAM_XTEA_EN
  function automatic word_t xtea_f(input word_t v);
    return ((v << 4) ^ (v >> 5)) + v;
  endfunction
`else
  logic unused_alg;
  assign unused_alg = alg;
`endif

  always_comb begin
    v0_o  = v0;
    v1_o  = v1;
    sum_o = sum;
    s_mid = sum;
`ifdef TEA_STREAM_XTEA_EN
    if (alg) begin
      if (!dec) begin
        v0_o  = v0 + (xtea_f(v1) ^ (sum + key_word(key, sum[1:0])));
        s_mid = sum + DELTA;
        v1_o  = v1 + (xtea_f(v0_o) ^ (s_mid + key_word(key, s_mid[12:11])));
      end else begin
        v1_o  = v1 - (xtea_f(v0) ^ (sum + key_word(key, sum[12:11])));
        s_mid = sum - DELTA;
        v0_o  = v0 - (xtea_f(v1_o) ^ (s_mid + key_word(key, s_mid[1:0])));
      end
      sum_o = s_mid;
    end else
`endif
    if (!dec) begin
      s_mid = sum + DELTA;
      v0_o  = v0 + tea_f(v1, s_mid, k0, k1);
      v1_o  = v1 + tea_f(v0_o, s_mid, k2, k3);
      sum_o = s_mid;
    end else begin
      // Exact inverse: undo v1 first, then v0, and step sum back last.
      v1_o  = v1 - tea_f(v0, sum, k2, k3);
      v0_o  = v0 - tea_f(v1_o, sum, k0, k1);
      sum_o = sum - DELTA;
    end
  end

endmodule

// File: rtl/tea_stream_engine.sv
// rtl/tea_stream_engine.sv - iterative 64-bit TEA block engine with valid/ready streams; XTEA with TEA_STREAM_XTEA_EN
module tea_stream_engine
  import tea_pkg::*;
#(
  parameter int          NUM_CYCLES     = 32,
  parameter int          ROUNDS_PER_CLK = 1,
  parameter logic [31:0] DELTA          = tea_pkg::DELTA
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [63:0]  i_data,
  input  logic [127:0] i_key,
  input  logic         i_dec,
  input  logic         i_alg,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [63:0]  o_data,
  output logic         o_busy
);

  localparam int          STEPS   = NUM_CYCLES / ROUNDS_PER_CLK;
  localparam int          CW      = $clog2(STEPS + 1);
  localparam logic [31:0] DEC_SUM = dec_init_sum(DELTA, NUM_CYCLES);
  localparam logic [CW-1:0] LAST  = CW'(STEPS - 1);

  generate
    if (NUM_CYCLES < 1 || NUM_CYCLES > 64) begin : g_bad_cycles
      $fatal(1, "tea_stream_engine: NUM_CYCLES must be in 1..64");
    end
    if (ROUNDS_PER_CLK < 1 || (NUM_CYCLES % ROUNDS_PER_CLK) != 0) begin : g_bad_unroll
      $fatal(1, "tea_stream_engine: ROUNDS_PER_CLK must divide NUM_CYCLES");
    end
  endgenerate

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  word_t         v0_q, v1_q, sum_q;
  key_t          key_q;
  logic          dec_q;
  logic          alg_q;

`ifndef TEA_STREAM_XTEA_EN
  logic unused_alg;
  assign alg_q      = 1'b0;
  assign unused_alg = i_alg;
`endif

  word_t v0_c  [0:ROUNDS_PER_CLK];
  word_t v1_c  [0:ROUNDS_PER_CLK];
  word_t sum_c [0:ROUNDS_PER_CLK];

  assign v0_c[0]  = v0_q;
  assign v1_c[0]  = v1_q;
  assign sum_c[0] = sum_q;

  // Unrolled cycles are chained combinationally within a single clock.
  generate
    for (genvar g = 0; g < ROUNDS_PER_CLK; g++) begin : g_round
      tea_round #(.DELTA(DELTA)) u_round (
        .v0    (v0_c[g]),
        .v1    (v1_c[g]),
        .sum   (sum_c[g]),
        .key   (key_q),
        .dec   (dec_q),
        .alg   (alg_q),
        .v0_o  (v0_c[g+1]),
        .v1_o  (v1_c[g+1]),
        .sum_o (sum_c[g+1])
      );
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      v0_q    <= '0;
      v1_q    <= '0;
      sum_q   <= '0;
      key_q   <= '0;
      dec_q   <= 1'b0;
`ifdef TEA_STREAM_XTEA_EN
      alg_q   <= 1'b0;
`endif
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
      o_data  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_valid && o_ready) begin
            v0_q    <= i_data[31:0];
            v1_q    <= i_data[63:32];
            key_q   <= i_key;
            dec_q   <= i_dec;
`ifdef TEA_STREAM_XTEA_EN
            alg_q   <= i_alg;
`endif
            sum_q   <= i_dec ? DEC_SUM : '0;
            cnt_q   <= '0;
            o_ready <= 1'b0;
            o_busy  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          v0_q  <= v0_c[ROUNDS_PER_CLK];
          v1_q  <= v1_c[ROUNDS_PER_CLK];
          sum_q <= sum_c[ROUNDS_PER_CLK];
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            o_data  <= {v1_c[ROUNDS_PER_CLK], v0_c[ROUNDS_PER_CLK]};
            o_valid <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          // o_ready returns a cycle after the result handshake, never in the same one.
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            o_busy  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tea_stream_engine.sv
// tb/tb_tea_stream_engine.sv - scoreboard bench for tea_stream_engine; XTEA scenario with TEA_STREAM_XTEA_EN
module tb_tea_stream_engine;

  localparam int          NC  = 32;
  localparam int          RPC = 1;
  localparam int          LAT = NC / RPC + 1;
  localparam logic [31:0] DLT = 32'h9E3779B9;

  logic         i_clk = 1'b0;
  logic         i_rstn;
  logic         i_valid;
  logic         o_ready;
  logic [63:0]  i_data;
  logic [127:0] i_key;
  logic         i_dec;
  logic         i_alg;
  logic         o_valid;
  logic         i_ready;
  logic [63:0]  o_data;
  logic         o_busy;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  tea_stream_engine #(.NUM_CYCLES(NC), .ROUNDS_PER_CLK(RPC)) dut (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .i_key   (i_key),
    .i_dec   (i_dec),
    .i_alg   (i_alg),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_busy  (o_busy)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [63:0] model(input logic [63:0] d, input logic [127:0] k,
                                        input bit dec, input bit alg);
    logic [31:0] v0, v1, s;
    logic [31:0] kw[4];
    v0 = d[31:0];
    v1 = d[63:32];
    for (int i = 0; i < 4; i++) kw[i] = k[32*i +: 32];
    s = dec ? 32'(DLT * 32'(NC)) : 32'h0;
    for (int c = 0; c < NC; c++) begin
      if (alg && !dec) begin
        v0 += (((v1 << 4) ^ (v1 >> 5)) + v1) ^ (s + kw[s[1:0]]);
        s  += DLT;
        v1 += (((v0 << 4) ^ (v0 >> 5)) + v0) ^ (s + kw[s[12:11]]);
      end else if (alg) begin
        v1 -= (((v0 << 4) ^ (v0 >> 5)) + v0) ^ (s + kw[s[12:11]]);
        s  -= DLT;
        v0 -= (((v1 << 4) ^ (v1 >> 5)) + v1) ^ (s + kw[s[1:0]]);
      end else if (!dec) begin
        s  += DLT;
        v0 += ((v1 << 4) + kw[0]) ^ (v1 + s) ^ ((v1 >> 5) + kw[1]);
        v1 += ((v0 << 4) + kw[2]) ^ (v0 + s) ^ ((v0 >> 5) + kw[3]);
      end else begin
        v1 -= ((v0 << 4) + kw[2]) ^ (v0 + s) ^ ((v0 >> 5) + kw[3]);
        v0 -= ((v1 << 4) + kw[0]) ^ (v1 + s) ^ ((v1 >> 5) + kw[1]);
        s  -= DLT;
      end
    end
    return {v1, v0};
  endfunction

  // Accept edge counts as clock 1; inputs are scrambled afterwards to prove capture.
  task automatic send(input logic [63:0] d, input logic [127:0] k, input bit dec, input bit alg);
    i_data  = d;
    i_key   = k;
    i_dec   = dec;
    i_alg   = alg;
    i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_data  = {$urandom, $urandom};
    i_key   = {$urandom, $urandom, $urandom, $urandom};
    i_dec   = ~dec;
    i_alg   = ~alg;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!o_valid && lat < LAT + 40) begin
      @(posedge i_clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
  endtask

  task automatic run_block(input logic [63:0] d, input logic [127:0] k, input bit dec, input bit alg,
                           output logic [63:0] got, output int lat, output bit seen);
    send(d, k, dec, alg);
    wait_valid(lat);
    seen = o_valid;
    got  = o_data;
    if (seen) consume();
  endtask

  task automatic test_reset();
    i_rstn = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_dec = 1'b0; i_alg = 1'b0;
    i_data = '0; i_key = '0;
    repeat (3) @(posedge i_clk);
    #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    checks++; if (o_data !== 64'h0) begin errors++; $display("FAIL reset_data: got %h want 0", o_data); end
    i_rstn = 1'b1;
    @(posedge i_clk); #1;
  endtask

  task automatic test_known_vector();
    logic [63:0] got, exp;
    int lat;
    bit seen;
    exp_q.push_back(64'h94BAA940_41EA3A0A);
    run_block(64'h0, 128'h0, 1'b0, 1'b0, got, lat, seen);
    exp = exp_q.pop_front();
    checks++; if (!seen) begin errors++; $display("FAIL enc0_timeout: o_valid never rose within %0d clocks", lat); end
    checks++; if (got !== exp) begin errors++; $display("FAIL enc0_data: got %h want %h", got, exp); end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL enc0_latency: got %0d want %0d", lat, LAT); end
    checks++; if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
      errors++; $display("FAIL enc0_idle: ready=%b busy=%b want 1 0", o_ready, o_busy);
    end
  endtask

  task automatic test_decrypt_vector();
    logic [63:0] got, exp;
    int lat;
    bit seen;
    exp_q.push_back(64'h0);
    run_block(64'h94BAA940_41EA3A0A, 128'h0, 1'b1, 1'b0, got, lat, seen);
    exp = exp_q.pop_front();
    checks++; if (!seen || got !== exp) begin errors++; $display("FAIL dec0_data: seen=%b got %h want %h", seen, got, exp); end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL dec0_latency: got %0d want %0d", lat, LAT); end
  endtask

  task automatic test_roundtrip();
    logic [63:0] d, e, got, exp;
    logic [127:0] k;
    int lat;
    bit seen;
    for (int n = 0; n < 150; n++) begin
      d = {$urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      e = model(d, k, 1'b0, 1'b0);
      exp_q.push_back(e);
      run_block(d, k, 1'b0, 1'b0, got, lat, seen);
      exp = exp_q.pop_front();
      checks++; if (!seen || got !== exp) begin errors++; $display("FAIL rt_enc[%0d]: got %h want %h", n, got, exp); end
      exp_q.push_back(d);
      run_block(e, k, 1'b1, 1'b0, got, lat, seen);
      exp = exp_q.pop_front();
      checks++; if (!seen || got !== exp) begin errors++; $display("FAIL rt_dec[%0d]: got %h want %h", n, got, exp); end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] d;
    logic [127:0] k;
    int lat;
    d = 64'h0123_4567_89AB_CDEF;
    k = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    exp_q.push_back(model(d, k, 1'b0, 1'b0));
    send(d, k, 1'b0, 1'b0);
    wait_valid(lat);
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout: o_valid=%b want 1", o_valid); end
    for (int c = 0; c < 20; c++) begin
      i_valid = 1'($urandom);
      i_data  = {$urandom, $urandom};
      @(posedge i_clk); #1;
      checks++;
      if (o_data !== exp_q[0] || o_ready !== 1'b0 || o_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: data=%h ready=%b valid=%b want %h 0 1", c, o_data, o_ready, o_valid, exp_q[0]);
      end
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_same_cycle_ready: got %b want 0", o_ready); end
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    void'(exp_q.pop_front());
    checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
      errors++; $display("FAIL bp_release: valid=%b ready=%b busy=%b want 0 1 0", o_valid, o_ready, o_busy);
    end
    repeat (3) @(posedge i_clk);
    #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL bp_no_queue: busy=%b want 0", o_busy); end
  endtask

  task automatic test_async_reset();
    logic [63:0] d, got, exp;
    logic [127:0] k;
    int lat;
    bit seen;
    d = {$urandom, $urandom};
    k = {$urandom, $urandom, $urandom, $urandom};
    exp_q.push_back(model(d, k, 1'b0, 1'b0));
    send(d, k, 1'b0, 1'b0);
    repeat (9) @(posedge i_clk);
    #2;
    i_rstn = 1'b0;
    #1;
    exp_q.delete();
    checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b0 || o_data !== 64'h0) begin
      errors++; $display("FAIL arst_outputs: ready=%b valid=%b busy=%b data=%h want 1 0 0 0", o_ready, o_valid, o_busy, o_data);
    end
    @(posedge i_clk); #1;
    i_rstn = 1'b1;
    @(posedge i_clk); #1;
    d = {$urandom, $urandom};
    k = {$urandom, $urandom, $urandom, $urandom};
    exp_q.push_back(model(d, k, 1'b1, 1'b0));
    run_block(d, k, 1'b1, 1'b0, got, lat, seen);
    exp = exp_q.pop_front();
    checks++; if (!seen || got !== exp) begin errors++; $display("FAIL arst_next: got %h want %h", got, exp); end
  endtask

`ifdef TEA_STREAM_XTEA_EN
  task automatic test_xtea();
    logic [63:0] d, got, exp;
    logic [127:0] k;
    int lat;
    bit seen;
    exp_q.push_back(64'hF7131ED9_DEE9D4D8);
    run_block(64'h0, 128'h0, 1'b0, 1'b1, got, lat, seen);
    exp = exp_q.pop_front();
    checks++; if (!seen || got !== exp) begin errors++; $display("FAIL xtea_enc0: got %h want %h", got, exp); end
    exp_q.push_back(64'h0);
    run_block(64'hF7131ED9_DEE9D4D8, 128'h0, 1'b1, 1'b1, got, lat, seen);
    exp = exp_q.pop_front();
    checks++; if (!seen || got !== exp) begin errors++; $display("FAIL xtea_dec0: got %h want %h", got, exp); end
    for (int n = 0; n < 10; n++) begin
      d = {$urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      exp_q.push_back(model(d, k, 1'b0, 1'b1));
      run_block(d, k, 1'b0, 1'b1, got, lat, seen);
      exp = exp_q.pop_front();
      checks++; if (!seen || got !== exp) begin errors++; $display("FAIL xtea_enc[%0d]: got %h want %h", n, got, exp); end
      exp_q.push_back(d);
      run_block(got, k, 1'b1, 1'b1, got, lat, seen);
      exp = exp_q.pop_front();
      checks++; if (!seen || got !== exp) begin errors++; $display("FAIL xtea_dec[%0d]: got %h want %h", n, got, exp); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_known_vector();
    test_decrypt_vector();
    test_roundtrip();
    test_backpressure();
    test_async_reset();
`ifdef TEA_STREAM_XTEA_EN
    test_xtea();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
